// File: rtl/afu_pkg.sv
// rtl/afu_pkg.sv - PSL command field layout, throttle state encoding and parity helper
package afu_pkg;

    localparam int SIZE_W   = 12;
    localparam int ADDR_W   = 64;
    localparam int ABT_W    = 3;
    localparam int COM_W    = 13;
    localparam int TAG_W    = 8;

    localparam int SIZE_LSB = 0;
    localparam int ADDR_LSB = SIZE_LSB + SIZE_W;
    localparam int ABT_LSB  = ADDR_LSB + ADDR_W;
    localparam int COM_LSB  = ABT_LSB + ABT_W;
    localparam int TAG_LSB  = COM_LSB + COM_W;

    localparam int CMD_WIDTH = TAG_LSB + TAG_W;
    localparam int CREDIT_W  = 8;
    localparam int RESP_W    = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } throttle_state_e;

    // Bit that makes the total number of ones (value plus bit) odd.
    function automatic logic odd_parity64(input logic [63:0] value);
        return ~(^value);
    endfunction

endpackage

// File: rtl/command_fifo.sv
// rtl/command_fifo.sv - show-ahead command FIFO with occupancy count; storage is not reset
module command_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 100
) (
    input  logic                     clock,
    input  logic                     rstn_in,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH[PTR_W:0]);
    assign do_pop    = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psl_command_throttle.sv
// rtl/psl_command_throttle.sv - credit-throttled PSL command issue; PSL_COMMAND_PARITY_EN adds output parity
module psl_command_throttle
    import afu_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CMD_W      = CMD_WIDTH
) (
    input  logic                        clock,
    input  logic                        rstn_in,
    input  logic                        enabled_in,
    input  logic [CREDIT_W-1:0]         room_in,
    input  logic                        cmd_in_valid,
    input  logic [CMD_W-1:0]            cmd_in,
    output logic                        cmd_in_ready,
    input  logic                        response_valid,
    input  logic [RESP_W-1:0]           response_credits,
    output logic                        cmd_out_valid,
    output logic [CMD_W-1:0]            cmd_out,
    output logic [1:0]                  cmd_out_parity,
    output logic [CREDIT_W-1:0]         credits_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_out,
    output logic                        credit_overflow_error
);

    throttle_state_e     state;
    logic [CREDIT_W-1:0] credits;
    logic [CREDIT_W-1:0] room_cap;
    logic [CMD_W-1:0]    head;
    logic                fifo_empty;
    logic                fifo_full;
    logic                issue;
    logic                accept;
    logic signed [9:0]   credit_sum;
    logic                credit_hi;
    logic                credit_lo;
    logic [CREDIT_W-1:0] credit_clamped;

    assign issue        = (state != ST_IDLE) && !fifo_empty && (credits != '0);
    assign cmd_in_ready = (state == ST_RUN) && (!fifo_full || issue);
    assign accept       = cmd_in_valid && cmd_in_ready;

    command_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clock     (clock),
        .rstn_in   (rstn_in),
        .push      (accept),
        .push_data (cmd_in),
        .pop       (issue),
        .head_data (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count_out)
    );

    // Ten signed bits cover every credit +/- one issue +/- a signed 9-bit return.
    always_comb begin
        credit_sum = $signed({2'b00, credits});
        if (issue) begin
            credit_sum = credit_sum - 10'sd1;
        end
        if (response_valid) begin
            credit_sum = credit_sum + $signed({response_credits[RESP_W-1], response_credits});
        end
        credit_hi = credit_sum > $signed({2'b00, room_cap});
        credit_lo = credit_sum[9];
        if (credit_hi) begin
            credit_clamped = room_cap;
        end else if (credit_lo) begin
            credit_clamped = '0;
        end else begin
            credit_clamped = credit_sum[CREDIT_W-1:0];
        end
    end

`ifdef PSL_COMMAND_PARITY_EN
    logic [1:0] parity_q;
    assign cmd_out_parity = parity_q;
`else
    assign cmd_out_parity = 2'b00;
`endif

    assign credits_out = credits;

    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            state                 <= ST_IDLE;
            credits               <= '0;
            room_cap              <= '0;
            cmd_out_valid         <= 1'b0;
            cmd_out               <= '0;
            credit_overflow_error <= 1'b0;
`ifdef PSL_COMMAND_PARITY_EN
            parity_q              <= 2'b00;
`endif
        end else begin
            cmd_out_valid <= issue;
            cmd_out       <= issue ? head : '0;
`ifdef PSL_COMMAND_PARITY_EN
            parity_q      <= issue ? {odd_parity64(head[ADDR_LSB +: ADDR_W]),
                                      odd_parity64({56'd0, head[TAG_LSB +: TAG_W]})} : 2'b00;
`endif
            case (state)
                ST_IDLE: begin
                    // Nothing is outstanding while idle, so any return is bogus.
                    if (response_valid) begin
                        credit_overflow_error <= 1'b1;
                    end
                    if (enabled_in) begin
                        state    <= ST_RUN;
                        credits  <= room_in;
                        room_cap <= room_in;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    credits <= credit_clamped;
                    if (credit_hi || credit_lo) begin
                        credit_overflow_error <= 1'b1;
                    end
                    if (state == ST_RUN && !enabled_in) begin
                        state <= ST_DRAIN;
                    end else if (state == ST_DRAIN && enabled_in) begin
                        state <= ST_RUN;
                    end else if (state == ST_DRAIN && fifo_empty && credits == room_cap) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
